dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory target for the pipelined core's load/store port. Accepts one request at a
//  time over a valid/ready channel, and performs byte/half/word writes with lane masking.
//  Returns read data and an error flag over a valid/ready response channel after a fixed
//  latency. Sits between the core's MEM-stage bus adapter and the on-chip data RAM.
// PARAMETERS
//  ADDR_WIDTH  10  word-address bits; RAM depth = 2**ADDR_WIDTH 32-bit words
//  LATENCY     2   accept edge -> resp_valid, in cycles; legal range >= 1
// PORTS
//  clk         in   1   single clock, all logic on posedge
//  rst         in   1   synchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept a request this cycle
//  req_addr    in   32  byte address
//  req_write   in   1   1 = store, 0 = load
//  req_size    in   2   00 byte, 01 half, 10 word (11 treated as word)
//  req_wdata   in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid  out  1   response present
//  resp_ready  in   1   requester accepts response
//  resp_rdata  out  32  load data, right-aligned, zero-filled above size; 0 for stores/errors
//  resp_err    out  1   misaligned access
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0.
//    req_ready=0 while rst high. RAM contents are not reset (sim init to 0).
//  - FSM IDLE/BUSY/RESP; single outstanding transaction.
//    IDLE: req_ready=1. req_valid=1 at edge T0 = accept.
//      Capture addr/size/write/wdata.
//      If LATENCY==1 go to RESP, else go to BUSY with counter=LATENCY-2.
//    BUSY: req_ready=0. counter==0 -> RESP, else decrement.
//    RESP: resp_valid=1, req_ready=0.
//      rdata/err are held stable until the edge where resp_ready=1, then -> IDLE.
//  - resp_valid rises exactly LATENCY cycles after the accept edge.
//  - The resp handshake cycle has req_ready=0, so requests cannot be issued back-to-back.
//    Minimum spacing between accepts is LATENCY+1 cycles.
//  - Word index = req_addr[ADDR_WIDTH+1:2]. Upper bits are ignored, so addresses wrap/alias.
//  - Lane offset = req_addr[1:0].
//    Store: wdata is shifted left by 8*offset. Byte-enable mask is 0001/0011/1111 shifted
//    left by offset. Only enabled lanes are written.
//    Load: rdata = (word >> 8*offset), masked to 8/16/32 bits. No sign extension; the
//    core's WB stage extends.
//  - Misaligned = (half & addr[0]) | (word & addr[1:0]!=0).
//    Response: resp_err=1, resp_rdata=0, no RAM write, same latency as a good access.
//  - Stores are committed to RAM at the accept edge. A load accepted later observes them.
//  - Store response: resp_rdata=0, resp_err=0 unless misaligned.
//  - resp_rdata/resp_err are 0 whenever resp_valid=0.
//  - Reset mid-operation (BUSY or RESP): transaction dropped, no resp_valid, state IDLE.
//    A store already committed at its accept edge stays in RAM.
//  - req_* inputs are ignored whenever req_ready=0.
// TESTING
//  1. Hold rst 3 cycles, req_valid=1 -> req_ready=0, resp_valid=0, no accept.
//     Release rst -> req_ready=1 next cycle.
//  2. LATENCY=2: store word 0xDEADBEEF @0x10, then load word @0x10.
//     -> resp_valid 2 cycles after each accept; load rdata=0xDEADBEEF, err=0.
//  3. Store byte 0xAA @0x13; load word @0x10 -> 0xAAADBEEF.
//     Load byte @0x13 -> 0x000000AA. Load half @0x12 -> 0x0000AAAD.
//  4. Store half 0x1234 @0x11 -> resp_err=1, rdata=0.
//     Load word @0x10 -> 0xAAADBEEF (unchanged).
//  5. Hold resp_ready=0 for 5 cycles during a load response.
//     -> resp_valid/rdata stable, req_ready=0, concurrent req_valid ignored.
//     Raise resp_ready -> IDLE next cycle.
//  6. ADDR_WIDTH=10: store word 0x5 @0x1000 -> load @0x0 returns 0x5.
//     Assert rst in BUSY -> resp_valid never rises; req_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: one outstanding request,
// lane-masked stores committed at accept, fixed-latency valid/ready response.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [15:0] COUNT_LOAD = 16'(LATENCY >= 2 ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state, state_next;
  logic [15:0] counter, counter_next;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic                  accept;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            offset;
  logic                  misaligned;
  logic [3:0]            byte_en;
  logic [31:0]           wdata_shifted;
  logic [31:0]           rd_shifted;
  logic [31:0]           load_data;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  assign word_idx   = req_addr[ADDR_WIDTH+1:2];
  assign offset     = req_addr[1:0];
  assign misaligned = ((req_size == 2'b01) && offset[0]) ||
                      (req_size[1] && (offset != 2'b00));

  always_comb begin
    byte_en = 4'b1111;
    case (req_size)
      2'b00:   byte_en = 4'b0001 << offset;
      2'b01:   byte_en = 4'b0011 << offset;
      default: byte_en = 4'b1111;
    endcase
  end

  assign wdata_shifted = req_wdata << {offset, 3'b000};
  assign rd_shifted    = mem[word_idx] >> {offset, 3'b000};

  // Loads return the addressed lanes right-aligned and zero-filled; WB does extension.
  always_comb begin
    load_data = rd_shifted;
    case (req_size)
      2'b00:   load_data = {24'h0, rd_shifted[7:0]};
      2'b01:   load_data = {16'h0, rd_shifted[15:0]};
      default: load_data = rd_shifted;
    endcase
  end

  assign req_ready  = (state == IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_err   = resp_valid ? err_q : 1'b0;

  always_comb begin
    state_next   = state;
    counter_next = counter;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next   = BUSY;
            counter_next = COUNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (counter == 16'd0) begin
          state_next = RESP;
        end else begin
          counter_next = counter - 16'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Response payload is fixed at accept so it stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      counter <= 16'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      if (accept) begin
        err_q   <= misaligned;
        rdata_q <= (req_write || misaligned) ? 32'h0 : load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && req_write && !misaligned) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[word_idx][8*i +: 8] <= wdata_shifted[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (ADDR_WIDTH=10, LATENCY=2).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int passed = 0;

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  // Issues one request from IDLE and returns latency (0 = no response) and payload.
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                         input logic [31:0] wdata, input logic hold,
                         output int lat, output logic [31:0] rdata, output logic err);
    lat   = 0;
    rdata = 32'hx;
    err   = 1'bx;
    req_addr   = addr;
    req_write  = wr;
    req_size   = size;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    resp_ready = !hold;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (resp_valid) begin
        lat   = i;
        rdata = resp_rdata;
        err   = resp_err;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!hold && lat != 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h20;
    req_write  = 1'b1;
    req_size   = 2'b10;
    req_wdata  = 32'hFFFF_FFFF;
    resp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 1'b0) $display("[TB] FAIL reset_req_ready cyc%0d got %b want 0", c, req_ready);
      else passed++;
      checks++;
      if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0)
        $display("[TB] FAIL reset_resp cyc%0d got v=%b d=%h e=%b want 0/0/0", c, resp_valid, resp_rdata, resp_err);
      else passed++;
    end
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) $display("[TB] FAIL reset_release_ready got %b want 1", req_ready);
    else passed++;
  endtask

  task automatic test_store_load_word();
    int lat;
    logic [31:0] d;
    logic e;
    run_txn(32'h10, 1'b1, 2'b10, 32'hDEAD_BEEF, 1'b0, lat, d, e);
    checks++;
    if (lat !== 2 || d !== 32'h0 || e !== 1'b0)
      $display("[TB] FAIL store_word got lat=%0d d=%h e=%b want 2/00000000/0", lat, d, e);
    else passed++;
    run_txn(32'h10, 1'b0, 2'b10, 32'h0, 1'b0, lat, d, e);
    checks++;
    if (lat !== 2 || d !== 32'hDEAD_BEEF || e !== 1'b0)
      $display("[TB] FAIL load_word got lat=%0d d=%h e=%b want 2/deadbeef/0", lat, d, e);
    else passed++;
  endtask

  task automatic test_byte_half();
    int lat;
    logic [31:0] d;
    logic e;
    logic [31:0] addrs [5] = '{32'h10, 32'h13, 32'h12, 32'h11, 32'h10};
    logic [1:0]  sizes [5] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b01};
    logic [31:0] exps  [5] = '{32'hAAAD_BEEF, 32'h0000_00AA, 32'h0000_AAAD,
                               32'h0000_00BE, 32'h0000_BEEF};
    run_txn(32'h13, 1'b1, 2'b00, 32'hFFFF_FFAA, 1'b0, lat, d, e);
    checks++;
    if (lat !== 2 || d !== 32'h0 || e !== 1'b0)
      $display("[TB] FAIL store_byte got lat=%0d d=%h e=%b want 2/00000000/0", lat, d, e);
    else passed++;
    for (int k = 0; k < 5; k++) begin
      run_txn(addrs[k], 1'b0, sizes[k], 32'h0, 1'b0, lat, d, e);
      checks++;
      if (lat !== 2 || d !== exps[k] || e !== 1'b0)
        $display("[TB] FAIL load_lane%0d got lat=%0d d=%h e=%b want 2/%h/0", k, lat, d, e, exps[k]);
      else passed++;
    end
  endtask

  task automatic test_misaligned();
    int lat;
    logic [31:0] d;
    logic e;
    run_txn(32'h11, 1'b1, 2'b01, 32'h0000_1234, 1'b0, lat, d, e);
    checks++;
    if (lat !== 2 || d !== 32'h0 || e !== 1'b1)
      $display("[TB] FAIL misaligned_store got lat=%0d d=%h e=%b want 2/00000000/1", lat, d, e);
    else passed++;
    run_txn(32'h12, 1'b0, 2'b10, 32'h0, 1'b0, lat, d, e);
    checks++;
    if (lat !== 2 || d !== 32'h0 || e !== 1'b1)
      $display("[TB] FAIL misaligned_load got lat=%0d d=%h e=%b want 2/00000000/1", lat, d, e);
    else passed++;
    run_txn(32'h10, 1'b0, 2'b10, 32'h0, 1'b0, lat, d, e);
    checks++;
    if (lat !== 2 || d !== 32'hAAAD_BEEF || e !== 1'b0)
      $display("[TB] FAIL misaligned_no_write got lat=%0d d=%h e=%b want 2/aaadbeef/0", lat, d, e);
    else passed++;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] d;
    logic e;
    run_txn(32'h10, 1'b0, 2'b10, 32'h0, 1'b1, lat, d, e);
    checks++;
    if (lat !== 2 || d !== 32'hAAAD_BEEF)
      $display("[TB] FAIL bp_first got lat=%0d d=%h want 2/aaadbeef", lat, d);
    else passed++;
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_size  = 2'b10;
      req_addr  = 32'h10;
      req_wdata = 32'h0;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hAAAD_BEEF || req_ready !== 1'b0)
        $display("[TB] FAIL bp_hold cyc%0d got v=%b d=%h rdy=%b want 1/aaadbeef/0",
                 c, resp_valid, resp_rdata, req_ready);
      else passed++;
      @(posedge clk);
      #1;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("[TB] FAIL bp_release got v=%b rdy=%b want 0/1", resp_valid, req_ready);
    else passed++;
    run_txn(32'h10, 1'b0, 2'b10, 32'h0, 1'b0, lat, d, e);
    checks++;
    if (lat !== 2 || d !== 32'hAAAD_BEEF)
      $display("[TB] FAIL bp_ignored_store got lat=%0d d=%h want 2/aaadbeef", lat, d);
    else passed++;
  endtask

  task automatic test_alias_reset();
    int lat;
    logic [31:0] d;
    logic e;
    bit seen;
    run_txn(32'h1000, 1'b1, 2'b10, 32'h0000_0005, 1'b0, lat, d, e);
    run_txn(32'h0, 1'b0, 2'b10, 32'h0, 1'b0, lat, d, e);
    checks++;
    if (lat !== 2 || d !== 32'h0000_0005 || e !== 1'b0)
      $display("[TB] FAIL alias_load got lat=%0d d=%h e=%b want 2/00000005/0", lat, d, e);
    else passed++;
    req_addr   = 32'h0;
    req_write  = 1'b0;
    req_size   = 2'b10;
    req_valid  = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) $display("[TB] FAIL busy_reset_ready got %b want 1", req_ready);
    else passed++;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (resp_valid) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen !== 1'b0) $display("[TB] FAIL busy_reset_no_resp got %b want 0", seen);
    else passed++;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    #1;
    test_reset();
    test_store_load_word();
    test_byte_half();
    test_misaligned();
    test_backpressure();
    test_alias_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
